// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
//   state_e        : arbiter FSM states (IDLE, ACCESS, RESP)
//   PORT0 / PORT1  : requester IDs as carried on the winner signal
//   DEF_*          : default address width, data width and memory depth
package dmem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 32;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes and memory bus of the data-memory arbiter
//   p0_* / p1_*    : per-port req/we/addr/wdata in, gnt/done pulses out
//   rdata / err    : shared completion data, valid with a done pulse
//   mem_*          : single-port memory strobes, address, write data, read data
//   slave modport  : arbiter view; master modport: requesters + memory view
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              p0_req, p0_we, p0_gnt, p0_done;
   logic              p1_req, p1_we, p1_gnt, p1_done;
   logic [ADDR_W-1:0] p0_addr, p1_addr, mem_addr;
   logic [DATA_W-1:0] p0_wdata, p1_wdata, mem_wdata, mem_rdata, rdata;
   logic              err, mem_re, mem_we;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_rdata,
      output p0_gnt, p0_done, p1_gnt, p1_done, rdata, err,
      output mem_addr, mem_wdata, mem_re, mem_we
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output mem_rdata,
      input  p0_gnt, p0_done, p1_gnt, p1_done, rdata, err,
      input  mem_addr, mem_wdata, mem_re, mem_we
   );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection for the two requesters
//   req0_i / req1_i : pending requests
//   last_i          : port granted most recently (round-robin build only)
//   valid_o         : some request is pending
//   win_o           : winning port ID, meaningful when valid_o is high
//   Macro DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic valid_o,
   output logic win_o
);

   assign valid_o = req0_i | req1_i;

`ifdef DMEM_ARB_RR_EN
   // on a tie the port that did not win last time goes next
   assign win_o = (req0_i & req1_i) ? ~last_i : (req0_i ? PORT0 : PORT1);
`else
   logic unused_last;
   assign unused_last = last_i;
   assign win_o = req0_i ? PORT0 : PORT1;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the 32 x 16 data memory
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : dmem_arbiter_if.slave -- requester handshakes and memory bus
//   Each access runs IDLE -> ACCESS (gnt + memory strobe) -> RESP (done + rdata/err).
//   All outputs come straight from registers. Macro DMEM_ARB_RR_EN enables
//   round-robin arbitration (default: port 0 fixed priority).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   state_e            state_q, state_d;
   logic              last_q, last_d, win_q, win_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic              err_q, err_d, re_q, re_d, mwe_q, mwe_d;
   logic [1:0]        gnt_q, gnt_d, done_q, done_d;
   logic              pick_v, pick_w, sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   dmem_arb_pick u_pick (
      .req0_i  (bus.p0_req),
      .req1_i  (bus.p1_req),
      .last_i  (last_q),
      .valid_o (pick_v),
      .win_o   (pick_w)
   );

   assign sel_we    = pick_w ? bus.p1_we    : bus.p0_we;
   assign sel_addr  = pick_w ? bus.p1_addr  : bus.p0_addr;
   assign sel_wdata = pick_w ? bus.p1_wdata : bus.p0_wdata;

   // strobes are decided at the grant edge so they are registered for the ACCESS cycle
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      re_d    = 1'b0;
      mwe_d   = 1'b0;
      case (state_q)
         IDLE: if (pick_v) begin
            state_d = ACCESS;
            last_d  = pick_w;
            win_d   = pick_w;
            we_d    = sel_we;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            gnt_d   = pick_w ? 2'b10 : 2'b01;
            re_d    = in_range(sel_addr) & ~sel_we;
            mwe_d   = in_range(sel_addr) & sel_we;
         end
         ACCESS: begin
            state_d = RESP;
            rdata_d = (in_range(addr_q) & ~we_q) ? bus.mem_rdata : '0;
            err_d   = ~in_range(addr_q);
            done_d  = win_q ? 2'b10 : 2'b01;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= PORT1;
         win_q   <= PORT0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         re_q    <= 1'b0;
         mwe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         re_q    <= re_d;
         mwe_q   <= mwe_d;
      end
   end

   assign bus.p0_gnt    = gnt_q[0];
   assign bus.p1_gnt    = gnt_q[1];
   assign bus.p0_done   = done_q[0];
   assign bus.p1_done   = done_q[1];
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_re    = re_q;
   assign bus.mem_we    = mwe_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic against a transaction-level model
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();
   dmem_arbiter dut (.clk(clk), .reset(rst), .bus(bus));

`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int vectors = 0;
   int miss = 0;

   logic [15:0] mem [32] = '{default: '0};
   logic [15:0] ref_mem [32] = '{default: '0};

   assign bus.mem_rdata = (bus.mem_addr < 8'd32) ? mem[bus.mem_addr[4:0]] : 16'hDEAD;
   always @(posedge clk) if (bus.mem_we && bus.mem_addr < 8'd32) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;

   logic [1:0] gnt, done, req;
   assign gnt  = {bus.p1_gnt, bus.p0_gnt};
   assign done = {bus.p1_done, bus.p0_done};
   assign req  = {bus.p1_req, bus.p0_req};

   // model: one transaction may start at most every 3 edges; a grant at edge g
   // shows gnt/strobe in the following cycle and done/rdata/err one cycle later
   int cyc = 0;
   int g_cyc = -100;
   bit last = 1'b1;
   bit g_p, g_we, g_in;
   logic [7:0]  m_addr = '0;
   logic [15:0] m_wdata = '0;
   logic [15:0] g_rd = '0;

   always @(posedge clk) begin
      bit p;
      cyc++;
      if (rst) begin
         g_cyc = -100;
         last = 1'b1;
         m_addr = '0;
         m_wdata = '0;
      end else if (cyc >= g_cyc + 3 && (bus.p0_req || bus.p1_req)) begin
         p = (bus.p0_req && bus.p1_req) ? (RR && !last) : bus.p1_req;
         g_p = p;
         g_cyc = cyc;
         last = p;
         g_we = p ? bus.p1_we : bus.p0_we;
         m_addr = p ? bus.p1_addr : bus.p0_addr;
         m_wdata = p ? bus.p1_wdata : bus.p0_wdata;
         g_in = m_addr < 8'd32;
         g_rd = (g_in && !g_we) ? ref_mem[m_addr[4:0]] : 16'h0;
         if (g_in && g_we) ref_mem[m_addr[4:0]] = m_wdata;
      end
   end

   always @(negedge clk) if (cyc > 0) begin
      logic [29:0] want, got;
      bit a, r;
      a = (g_cyc == cyc);
      r = (g_cyc == cyc - 1);
      want = {a && g_p, a && !g_p, r && g_p, r && !g_p, a && g_in && !g_we, a && g_in && g_we, m_addr, m_wdata};
      got = {bus.p1_gnt, bus.p0_gnt, bus.p1_done, bus.p0_done, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata};
      vectors++;
      if (got !== want) begin
         miss++;
         $display("FAIL outputs cyc=%0d got gnt1,gnt0,done1,done0,re,we=%b addr=%h wdata=%h, want %b addr=%h wdata=%h",
                  cyc, got[29:24], got[23:16], got[15:0], want[29:24], want[23:16], want[15:0]);
      end
      if (r) begin
         vectors++;
         if ({bus.err, bus.rdata} !== {!g_in, g_rd}) begin
            miss++;
            $display("FAIL response cyc=%0d got err=%b rdata=%h, want err=%b rdata=%h", cyc, bus.err, bus.rdata, !g_in, g_rd);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miss++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   task automatic drive(input bit p, input bit r, input bit we, input logic [7:0] a, input logic [15:0] d);
      if (p) begin
         bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
      end else begin
         bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
      end
   endtask

   task automatic xact(input bit p, input bit we, input logic [7:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic e, output int lg, output int ld,
                       output int nre, output int nwe);
      lg = -1; ld = -1; nre = 0; nwe = 0; rd = 'x; e = 1'bx;
      @(negedge clk);
      drive(p, 1'b1, we, a, d);
      for (int t = 1; t <= 10 && ld < 0; t++) begin
         @(negedge clk);
         if (gnt[p]) begin
            lg = t;
            drive(p, 1'b0, we, a, d);
         end
         nre += int'(bus.mem_re);
         nwe += int'(bus.mem_we);
         if (done[p]) begin
            ld = t; rd = bus.rdata; e = bus.err;
         end
      end
      drive(p, 1'b0, we, a, d);
   endtask

   initial begin
      logic [15:0] rd;
      logic e;
      int lg, ld, nre, nwe, n;
      logic [3:0] ord;
      int bal [2];
      drive(1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
      repeat (2) @(negedge clk);
      chk("reset_outputs", {gnt, done, bus.mem_re, bus.mem_we, bus.err, bus.rdata, bus.mem_addr}, 32'd0);
      chk("reset_wdata", bus.mem_wdata, 32'd0);
      rst = 1'b0;
      // preload word 5 through port 0
      xact(1'b0, 1'b1, 8'd5, 16'hBEEF, rd, e, lg, ld, nre, nwe);
      chk("preload_done_lat", ld, 2);
      // single read
      xact(1'b0, 1'b0, 8'd5, 16'h0, rd, e, lg, ld, nre, nwe);
      chk("read_gnt_lat", lg, 1);
      chk("read_done_lat", ld, 2);
      chk("read_rdata", rd, 32'hBEEF);
      chk("read_err", e, 0);
      chk("read_re_cycles", nre, 1);
      chk("read_we_cycles", nwe, 0);
      // write then read on port 1
      xact(1'b1, 1'b1, 8'd31, 16'h1234, rd, e, lg, ld, nre, nwe);
      chk("write_we_cycles", nwe, 1);
      chk("write_re_cycles", nre, 0);
      xact(1'b1, 1'b0, 8'd31, 16'h0, rd, e, lg, ld, nre, nwe);
      chk("readback_rdata", rd, 32'h1234);
      chk("readback_done_lat", ld, 2);
      // contention: both hold req for four grants
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 8'd1, 16'h0);
      drive(1'b1, 1'b1, 1'b0, 8'd2, 16'h0);
      n = 0;
      ord = '0;
      for (int t = 0; t < 20 && n < 4; t++) begin
         @(negedge clk);
         if (gnt != 2'b00) begin
            ord = {ord[2:0], gnt[1]};
            n++;
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'd1, 16'h0);
      drive(1'b1, 1'b0, 1'b0, 8'd2, 16'h0);
      chk("contention_grants", n, 4);
      chk("contention_order", ord, RR ? 4'b0101 : 4'b0000);
      repeat (3) @(negedge clk);
      // out of range
      xact(1'b0, 1'b0, 8'd40, 16'h0, rd, e, lg, ld, nre, nwe);
      chk("oob_rdata", rd, 0);
      chk("oob_err", e, 1);
      chk("oob_strobes", nre + nwe, 0);
      xact(1'b1, 1'b1, 8'd200, 16'h5555, rd, e, lg, ld, nre, nwe);
      chk("oob_write_err", e, 1);
      chk("oob_write_we", nwe, 0);
      // reset during the ACCESS cycle of a port 1 read
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 8'd5, 16'h0);
      n = 0;
      for (int t = 0; t < 5 && n == 0; t++) begin
         @(negedge clk);
         if (gnt[1]) n = 1;
      end
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'd5, 16'h0);
      chk("reset_mid_granted", n, 1);
      @(negedge clk);
      chk("reset_mid_outputs", {gnt, done, bus.mem_re, bus.mem_we, bus.err, bus.rdata, bus.mem_addr}, 32'd0);
      rst = 1'b0;
      n = 0;
      repeat (4) begin
         @(negedge clk);
         n += int'(done[1]);
      end
      chk("reset_mid_no_done", n, 0);
      xact(1'b0, 1'b0, 8'd5, 16'h0, rd, e, lg, ld, nre, nwe);
      chk("after_reset_rdata", rd, 32'hBEEF);
      // random traffic on both ports
      bal = '{0, 0};
      for (int c = 0; c < 1005; c++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (gnt[p]) bal[p]++;
            if (done[p]) bal[p]--;
            if (req[p] && (gnt[p] || c >= 1000))
               drive(p[0], 1'b0, 1'b0, 8'd0, 16'h0);
            else if (!req[p] && c < 1000 && $urandom_range(0, 2) == 0)
               drive(p[0], 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 39)), 16'($urandom));
         end
      end
      repeat (4) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (gnt[p]) bal[p]++;
            if (done[p]) bal[p]--;
         end
      end
      chk("random_gnt_done_p0", bal[0], 0);
      chk("random_gnt_done_p1", bal[1], 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

endmodule
